// File: rtl/cpu_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_arb
// Description : Two-port (instruction / data) to single system bus arbiter.
//               Each CPU port owns one pending-request register; a three-state
//               FSM (IDLE / ISSUE / WAIT) forwards one request at a time to the
//               system bus and returns a registered completion pulse to the
//               requesting port.
//               Build option: define CPU_BUS_ARB_RR_EN for round-robin
//               arbitration; otherwise the D-port wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================

package cpu_bus_arb_pkg;
    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;
    localparam int CPU_BEN_WIDTH  = 4;
endpackage

module cpu_bus_arb
    import cpu_bus_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      nrst,

    // Instruction port (read only)
    input  logic [CPU_ADDR_WIDTH-1:0] i_IAddr,
    input  logic                      i_IRdC,
    output logic [CPU_DATA_WIDTH-1:0] o_IData,
    output logic                      o_IRdy,
    output logic                      o_IErr,

    // Data port (read / write)
    input  logic [CPU_ADDR_WIDTH-1:0] i_DAddr,
    input  logic                      i_DCmd,
    input  logic                      i_DRnW,
    input  logic [CPU_BEN_WIDTH-1:0]  i_DBen,
    input  logic [CPU_DATA_WIDTH-1:0] i_DData,
    output logic [CPU_DATA_WIDTH-1:0] o_DData,
    output logic                      o_DRdy,
    output logic                      o_DErr,

    // System bus master
    output logic [CPU_ADDR_WIDTH-1:0] o_MAddr,
    output logic                      o_MCmd,
    output logic                      o_MRnW,
    output logic [CPU_BEN_WIDTH-1:0]  o_MBen,
    output logic [CPU_DATA_WIDTH-1:0] o_MData,
    input  logic [CPU_DATA_WIDTH-1:0] i_MData,
    input  logic                      i_MRdy,
    input  logic                      i_MErr
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CPU_BEN_WIDTH-1:0] c_BEN_ALL = {CPU_BEN_WIDTH{1'b1}};

    state_t                      r_state;
    state_t                      w_state_nxt;

    // Pending-request registers: the pending flag stays set while the request
    // is in flight, so a second command on the same port is dropped.
    logic                        r_ipend;
    logic [CPU_ADDR_WIDTH-1:0]   r_iaddr;
    logic                        r_dpend;
    logic [CPU_ADDR_WIDTH-1:0]   r_daddr;
    logic                        r_drnw;
    logic [CPU_BEN_WIDTH-1:0]    r_dben;
    logic [CPU_DATA_WIDTH-1:0]   r_dwdata;

    // Grant: 1 = D-port owns the bus, 0 = I-port
    logic                        r_gnt_d;
    logic                        w_pick_d;
    logic                        w_load_gnt;
    logic                        w_done;

    // Registered port responses
    logic                        r_irdy;
    logic                        r_ierr;
    logic [CPU_DATA_WIDTH-1:0]   r_irdata;
    logic                        r_drdy;
    logic                        r_derr;
    logic [CPU_DATA_WIDTH-1:0]   r_drdata;

    // Fields of the granted request
    logic [CPU_ADDR_WIDTH-1:0]   w_gaddr;
    logic                        w_grnw;
    logic [CPU_BEN_WIDTH-1:0]    w_gben;
    logic [CPU_DATA_WIDTH-1:0]   w_gdata;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef CPU_BUS_ARB_RR_EN
    // 1 = D-port was served last; reset value 0 lets the D-port win first tie
    logic r_last_d;

    // Round-robin pick: on a tie the port not served last wins
    always_comb begin
        w_pick_d = r_dpend & (~r_ipend | ~r_last_d);
    end

    // Remember which port was granted most recently
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last_d <= 1'b0;
        end else if (w_load_gnt) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // Fixed priority pick: the D-port always wins a tie
    always_comb begin
        w_pick_d = r_dpend;
    end
`endif

    // Select the granted request's fields; I-port is always a full-word read
    always_comb begin
        if (r_gnt_d) begin
            w_gaddr = r_daddr;
            w_grnw  = r_drnw;
            w_gben  = r_dben;
            w_gdata = r_dwdata;
        end else begin
            w_gaddr = r_iaddr;
            w_grnw  = 1'b1;
            w_gben  = c_BEN_ALL;
            w_gdata = '0;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and system bus outputs; bus fields are zero outside ISSUE/WAIT
    always_comb begin
        w_state_nxt = S_IDLE;
        w_load_gnt  = 1'b0;
        w_done      = 1'b0;
        o_MCmd      = 1'b0;
        o_MAddr     = '0;
        o_MRnW      = 1'b0;
        o_MBen      = '0;
        o_MData     = '0;
        case (r_state)
            S_IDLE: begin
                if (r_ipend || r_dpend) begin
                    w_state_nxt = S_ISSUE;
                    w_load_gnt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                o_MCmd      = 1'b1;
                o_MAddr     = w_gaddr;
                o_MRnW      = w_grnw;
                o_MBen      = w_gben;
                o_MData     = w_gdata;
            end
            S_WAIT: begin
                o_MAddr = w_gaddr;
                o_MRnW  = w_grnw;
                o_MBen  = w_gben;
                o_MData = w_gdata;
                if (i_MRdy || i_MErr) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the grant when leaving IDLE so it is stable through the transfer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_gnt_d <= 1'b0;
        end else if (w_load_gnt) begin
            r_gnt_d <= w_pick_d;
        end
    end

    // ------------------------------------------------------------------------
    // Pending-request capture
    // ------------------------------------------------------------------------
    // I-port request: capture on command when free, release on completion
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ipend <= 1'b0;
            r_iaddr <= '0;
        end else if (w_done && !r_gnt_d) begin
            r_ipend <= 1'b0;
        end else if (i_IRdC && !r_ipend) begin
            r_ipend <= 1'b1;
            r_iaddr <= i_IAddr;
        end
    end

    // D-port request: capture on command when free, release on completion
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_dpend  <= 1'b0;
            r_daddr  <= '0;
            r_drnw   <= 1'b0;
            r_dben   <= '0;
            r_dwdata <= '0;
        end else if (w_done && r_gnt_d) begin
            r_dpend <= 1'b0;
        end else if (i_DCmd && !r_dpend) begin
            r_dpend  <= 1'b1;
            r_daddr  <= i_DAddr;
            r_drnw   <= i_DRnW;
            r_dben   <= i_DBen;
            r_dwdata <= i_DData;
        end
    end

    // ------------------------------------------------------------------------
    // Port responses
    // ------------------------------------------------------------------------
    // One-cycle registered completion; error beats ready, data only on reads
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_irdy   <= 1'b0;
            r_ierr   <= 1'b0;
            r_irdata <= '0;
            r_drdy   <= 1'b0;
            r_derr   <= 1'b0;
            r_drdata <= '0;
        end else begin
            r_irdy   <= 1'b0;
            r_ierr   <= 1'b0;
            r_irdata <= '0;
            r_drdy   <= 1'b0;
            r_derr   <= 1'b0;
            r_drdata <= '0;
            if (w_done) begin
                if (r_gnt_d) begin
                    if (i_MErr) begin
                        r_derr <= 1'b1;
                    end else begin
                        r_drdy   <= 1'b1;
                        r_drdata <= r_drnw ? i_MData : '0;
                    end
                end else begin
                    if (i_MErr) begin
                        r_ierr <= 1'b1;
                    end else begin
                        r_irdy   <= 1'b1;
                        r_irdata <= i_MData;
                    end
                end
            end
        end
    end

    assign o_IRdy  = r_irdy;
    assign o_IErr  = r_ierr;
    assign o_IData = r_irdata;
    assign o_DRdy  = r_drdy;
    assign o_DErr  = r_derr;
    assign o_DData = r_drdata;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_arb
// Description : Self-checking bench for cpu_bus_arb. Table of single
//               transactions plus hand-written tie, drop, back-to-back and
//               reset-abort sequences; expected bus commands and port
//               responses are queued at stimulus time and popped by a monitor.
//               Honours CPU_BUS_ARB_RR_EN for tie-order expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_arb;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] i_IAddr = '0;
    logic        i_IRdC = 1'b0;
    logic [31:0] o_IData;
    logic        o_IRdy, o_IErr;
    logic [31:0] i_DAddr = '0;
    logic        i_DCmd = 1'b0;
    logic        i_DRnW = 1'b0;
    logic [3:0]  i_DBen = '0;
    logic [31:0] i_DData = '0;
    logic [31:0] o_DData;
    logic        o_DRdy, o_DErr;
    logic [31:0] o_MAddr;
    logic        o_MCmd, o_MRnW;
    logic [3:0]  o_MBen;
    logic [31:0] o_MData;
    logic [31:0] i_MData = '0;
    logic        i_MRdy = 1'b0;
    logic        i_MErr = 1'b0;

    always #5 clk = ~clk;

    cpu_bus_arb dut (
        .clk(clk), .nrst(nrst),
        .i_IAddr(i_IAddr), .i_IRdC(i_IRdC), .o_IData(o_IData), .o_IRdy(o_IRdy), .o_IErr(o_IErr),
        .i_DAddr(i_DAddr), .i_DCmd(i_DCmd), .i_DRnW(i_DRnW), .i_DBen(i_DBen), .i_DData(i_DData),
        .o_DData(o_DData), .o_DRdy(o_DRdy), .o_DErr(o_DErr),
        .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MRnW(o_MRnW), .o_MBen(o_MBen), .o_MData(o_MData),
        .i_MData(i_MData), .i_MRdy(i_MRdy), .i_MErr(i_MErr)
    );

    // Every DUT output concatenated, used for "all outputs zero" checks
    logic [159:0] all_out;
    assign all_out = {22'd0, o_IData, o_IRdy, o_IErr, o_DData, o_DRdy, o_DErr,
                      o_MAddr, o_MCmd, o_MRnW, o_MBen, o_MData};

    typedef struct {
        bit          port;    // 0 = I, 1 = D
        logic [31:0] addr;
        logic        rnw;     // also the expected o_MRnW
        logic [3:0]  ben;     // also the expected o_MBen
        logic [31:0] wdata;   // also the expected o_MData
        logic [31:0] mdata;   // bus read data returned by the responder
        logic        merr;
        logic        mrdy;
        int          delay;   // extra WAIT cycles before the bus answers
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    typedef struct packed { logic [31:0] addr; logic rnw; logic [3:0] ben; logic [31:0] data; } bus_t;
    typedef struct packed { logic rdy; logic err; logic [31:0] data; } rsp_t;
    typedef struct packed { logic [31:0] mdata; logic merr; logic mrdy; logic [7:0] delay; } drv_t;

    bus_t q_bus[$];
    rsp_t q_irsp[$];
    rsp_t q_drsp[$];
    drv_t q_drv[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_mcmd = 0;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // Queue all expectations belonging to one transaction
    task automatic expect_vec(input vec_t v, input bit with_rsp);
        q_bus.push_back('{v.addr, v.rnw, v.ben, v.wdata});
        q_drv.push_back('{v.mdata, v.merr, v.mrdy, 8'(v.delay)});
        if (with_rsp) begin
            if (v.port) q_drsp.push_back('{v.e_rdy, v.e_err, v.e_data});
            else        q_irsp.push_back('{v.e_rdy, v.e_err, v.e_data});
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        if (v.port) begin
            i_DCmd = 1'b1; i_DAddr = v.addr; i_DRnW = v.rnw; i_DBen = v.ben; i_DData = v.wdata;
        end else begin
            i_IRdC = 1'b1; i_IAddr = v.addr;
        end
    endtask

    task automatic clear_cmd();
        i_IRdC = 1'b0;
        i_DCmd = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (q_bus.size() == 0 && q_irsp.size() == 0 && q_drsp.size() == 0) break;
        end
        chk(name, 160'(q_bus.size() + q_irsp.size() + q_drsp.size()), 160'(0));
    endtask

    // Single isolated transaction with latency and bus-hold checks
    task automatic run_vec(input vec_t v);
        int t_cmd;
        int t_rsp;
        t_cmd = -1;
        t_rsp = -1;
        expect_vec(v, 1'b1);
        @(posedge clk); #1;
        drive_cmd(v);
        for (int c = 0; c < 64 && t_rsp < 0; c++) begin
            @(negedge clk);
            if (o_MCmd && t_cmd < 0) t_cmd = c;
            if (t_cmd >= 0 && c == t_cmd + 1)
                chk("wait_hold", 160'({o_MCmd, o_MAddr, o_MRnW, o_MBen, o_MData}),
                    160'({1'b0, v.addr, v.rnw, v.ben, v.wdata}));
            if (v.port ? (o_DRdy | o_DErr) : (o_IRdy | o_IErr)) begin
                t_rsp = c;
                chk("idle_bus_zero", 160'({o_MCmd, o_MAddr, o_MRnW, o_MBen, o_MData}), 160'(0));
            end
            @(posedge clk); #1;
            clear_cmd();
        end
        chk("lat_mcmd", 160'(t_cmd), 160'(2));
        chk("lat_rsp", 160'(t_rsp), 160'(4 + v.delay));
    endtask

    // Monitor: compare every bus command and port response with the queues
    always @(negedge clk) begin
        if (o_MCmd) begin
            n_mcmd++;
            if (q_bus.size() == 0) unexpected("mcmd_unexpected");
            else begin
                bus_t b;
                b = q_bus.pop_front();
                chk("mcmd_fields", 160'({o_MAddr, o_MRnW, o_MBen, o_MData}), 160'(b));
            end
        end
        if (o_IRdy || o_IErr) begin
            if (q_irsp.size() == 0) unexpected("irsp_unexpected");
            else begin
                rsp_t r;
                r = q_irsp.pop_front();
                chk("irsp", 160'({o_IRdy, o_IErr, o_IData}), 160'(r));
            end
        end
        if (o_DRdy || o_DErr) begin
            if (q_drsp.size() == 0) unexpected("drsp_unexpected");
            else begin
                rsp_t r;
                r = q_drsp.pop_front();
                chk("drsp", 160'({o_DRdy, o_DErr, o_DData}), 160'(r));
            end
        end
    end

    // Bus responder: answers each o_MCmd using the next queued behaviour
    initial begin
        forever begin
            @(negedge clk);
            if (o_MCmd && q_drv.size() > 0) begin
                drv_t d;
                d = q_drv.pop_front();
                @(posedge clk); #1;
                repeat (int'(d.delay)) begin @(posedge clk); #1; end
                i_MRdy = d.mrdy; i_MErr = d.merr; i_MData = d.mdata;
                @(posedge clk); #1;
                i_MRdy = 1'b0; i_MErr = 1'b0; i_MData = '0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vi, vd, va, vb, vr;
        logic [159:0] seen;
        int n0;
        bit got;

        //         port  addr           rnw   ben    wdata          mdata          merr  mrdy  dly  e_rdy e_err e_data
        tbl[0] = '{1'b0, 32'h0000_0100, 1'b1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 32'h0000_0200, 1'b0, 4'h3, 32'h0000_1234, 32'hA5A5_A5A5, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[2] = '{1'b1, 32'h0000_0300, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b1, 2, 1'b1, 1'b0, 32'hCAFE_F00D};
        tbl[3] = '{1'b1, 32'h0000_0304, 1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h0000_0000};
        tbl[4] = '{1'b0, 32'h0000_0104, 1'b1, 4'hF, 32'h0000_0000, 32'h8765_4321, 1'b1, 1'b0, 1, 1'b0, 1'b1, 32'h0000_0000};
        tbl[5] = '{1'b1, 32'h0000_0308, 1'b1, 4'hC, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, 1, 1'b1, 1'b0, 32'h1234_5678};
        tbl[6] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[7] = '{1'b1, 32'h0000_030C, 1'b0, 4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out, 160'(0));
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (2) @(posedge clk);

        // Table of isolated transactions
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);
        wait_drain("table_drain", 50);

        // Tie: D alone first, then I and D in the same cycle
        vd = tbl[5];
        vi = tbl[0];
        vi.addr = 32'h0000_0180; vi.mdata = 32'h1111_2222; vi.e_data = 32'h1111_2222;
        run_vec(tbl[2]);
`ifdef CPU_BUS_ARB_RR_EN
        expect_vec(vi, 1'b1);
        expect_vec(vd, 1'b1);
`else
        expect_vec(vd, 1'b1);
        expect_vec(vi, 1'b1);
`endif
        @(posedge clk); #1;
        drive_cmd(vi);
        drive_cmd(vd);
        @(posedge clk); #1;
        clear_cmd();
        wait_drain("tie_drain", 100);

        // Second I command while I is pending is dropped
        n0 = n_mcmd;
        va = tbl[0];
        va.addr = 32'h0000_0400;
        vb = va;
        vb.addr = 32'h0000_0500;
        expect_vec(va, 1'b1);
        @(posedge clk); #1;
        drive_cmd(va);
        @(posedge clk); #1;
        drive_cmd(vb);
        @(posedge clk); #1;
        clear_cmd();
        wait_drain("drop_drain", 50);
        repeat (6) @(negedge clk);
        chk("drop_one_mcmd", 160'(n_mcmd - n0), 160'(1));

        // New I command accepted in the same cycle o_IRdy pulses
        va = tbl[0];
        va.addr = 32'h0000_0600; va.mdata = 32'h3333_4444; va.e_data = 32'h3333_4444;
        vb = tbl[0];
        vb.addr = 32'h0000_0604; vb.mdata = 32'h5555_6666; vb.e_data = 32'h5555_6666;
        expect_vec(va, 1'b1);
        expect_vec(vb, 1'b1);
        @(posedge clk); #1;
        drive_cmd(va);
        @(posedge clk); #1;
        clear_cmd();
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (o_IRdy) got = 1'b1;
        end
        chk("b2b_first_rdy", 160'(got), 160'(1));
        drive_cmd(vb);
        @(posedge clk); #1;
        clear_cmd();
        wait_drain("b2b_drain", 50);

        // Reset during WAIT; the late bus answer must be discarded
        vr = tbl[2];
        vr.addr = 32'h0000_0700; vr.delay = 5; vr.mdata = 32'h0000_0055;
        expect_vec(vr, 1'b0);
        @(posedge clk); #1;
        drive_cmd(vr);
        @(posedge clk); #1;
        clear_cmd();
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_MCmd) got = 1'b1;
        end
        chk("rst_mcmd_seen", 160'(got), 160'(1));
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("rst_mid_outputs", all_out, 160'(0));
        @(posedge clk); #1;
        nrst = 1'b1;
        seen = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            seen = seen | all_out;
        end
        chk("post_rst_outputs", seen, 160'(0));
        chk("post_rst_queues", 160'(q_drv.size() + q_bus.size()), 160'(0));

        // Bus still usable after the abort
        run_vec(tbl[1]);
        wait_drain("final_drain", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
